modmul_arbiter: RTL and testbench

MODMUL_ARBITER -- requirements
Module: modmul_arbiter

---
 rtl/ecdsa_pkg.sv | 17 +
 rtl/modmul_arbiter_rr_pick.sv | 28 ++
 rtl/modmul_arbiter.sv | 150 +++++++++++++++
 tb/tb_modmul_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecdsa_pkg.sv
// Shared constants and types for the ECDSA datapath: operand width, the secp256k1
// field prime and the modmul arbiter FSM state encoding.
package ecdsa_pkg;

    localparam int W = 256;

    localparam logic [255:0] P_CONST =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/modmul_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after last_grant+1
// (wrapping) wins, returned one-hot. Requires N_REQ >= 2.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int LGW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LGW-1:0]   last_grant,
    output logic [N_REQ-1:0] winner
);

    logic [LGW:0]         sh;
    logic [2*N_REQ-1:0]   req_dbl;
    logic [2*N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]     rot_low;
    logic [N_REQ-1:0]     first_bit;
    logic [2*N_REQ-1:0]   win_dbl;

    // Rotate so the search start lands at bit 0, isolate the lowest set bit, rotate back.
    assign sh        = {1'b0, last_grant} + (LGW+1)'(1);
    assign req_dbl   = {req, req};
    assign req_rot   = req_dbl >> sh;
    assign rot_low   = req_rot[N_REQ-1:0];
    assign first_bit = rot_low & (~rot_low + N_REQ'(1));
    assign win_dbl   = {first_bit, first_bit} << sh;
    assign winner    = win_dbl[2*N_REQ-1:N_REQ];

endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter sharing one mod_mul among N_REQ requesters.
// Optional watchdog abort enabled by defining MODMUL_ARB_WDOG_EN.
module modmul_arbiter
    import ecdsa_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int W           = ecdsa_pkg::W,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       r,
    output logic               err,
    output logic               mm_start,
    output logic [W-1:0]       mm_a,
    output logic [W-1:0]       mm_b,
    input  logic [W-1:0]       mm_r,
    input  logic               mm_done
);

    localparam int LGW = $clog2(N_REQ);

    state_t             state_reg;
    logic [N_REQ-1:0]   gnt_reg;
    logic [N_REQ-1:0]   done_reg;
    logic               mm_start_reg;
    logic [W-1:0]       mm_a_reg;
    logic [W-1:0]       mm_b_reg;
    logic [W-1:0]       r_reg;
    logic [LGW-1:0]     last_grant_reg;

    logic [N_REQ-1:0]   winner;
    logic [LGW-1:0]     gnt_idx;
    logic [W-1:0]       sel_a;
    logic [W-1:0]       sel_b;
    logic [W-1:0]       a_masked [N_REQ];
    logic [W-1:0]       b_masked [N_REQ];
    logic               wdog_fire;

    rr_pick #(.N_REQ(N_REQ), .LGW(LGW)) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_reg),
        .winner     (winner)
    );

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_masked[gi] = req_a[gi*W +: W] & {W{winner[gi]}};
            assign b_masked[gi] = req_b[gi*W +: W] & {W{winner[gi]}};
        end
    endgenerate

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a = sel_a | a_masked[i];
            sel_b = sel_b | b_masked[i];
            if (gnt_reg[i]) gnt_idx = LGW'(i);
        end
    end

`ifdef MODMUL_ARB_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);

    logic [WDW-1:0] wdog_cnt_reg;
    logic           err_reg;

    // Fires on the WDOG_CYCLES-th consecutive WAIT cycle without mm_done.
    assign wdog_fire = (state_reg == ST_WAIT) && !mm_done &&
                       (wdog_cnt_reg == WDW'(WDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            err_reg <= wdog_fire;
            if (state_reg == ST_WAIT) wdog_cnt_reg <= wdog_cnt_reg + WDW'(1);
            else                      wdog_cnt_reg <= '0;
        end
    end

    assign err = err_reg;
`else
    // No watchdog: this term is constant false for any legal WDOG_CYCLES.
    assign wdog_fire = (WDOG_CYCLES < 0);
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            gnt_reg        <= '0;
            done_reg       <= '0;
            mm_start_reg   <= 1'b0;
            mm_a_reg       <= '0;
            mm_b_reg       <= '0;
            r_reg          <= '0;
            last_grant_reg <= LGW'(N_REQ - 1);
        end else begin
            done_reg     <= '0;
            mm_start_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_reg   <= winner;
                        mm_a_reg  <= sel_a;
                        mm_b_reg  <= sel_b;
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mm_start_reg <= 1'b1;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mm_done) begin
                        r_reg     <= mm_r;
                        done_reg  <= gnt_reg;
                        state_reg <= ST_RESP;
                    end else if (wdog_fire) begin
                        r_reg     <= '0;
                        done_reg  <= gnt_reg;
                        state_reg <= ST_RESP;
                    end
                end
                default: begin
                    last_grant_reg <= gnt_idx;
                    gnt_reg        <= '0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign done     = done_reg;
    assign r        = r_reg;
    assign mm_start = mm_start_reg;
    assign mm_a     = mm_a_reg;
    assign mm_b     = mm_b_reg;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a behavioural mod_mul stub and a scoreboard
// of expected completions; exercises the watchdog when MODMUL_ARB_WDOG_EN is defined.
module tb_modmul_arbiter;

    localparam int N  = 4;
    localparam int WB = 256;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] HALF =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*WB-1:0]   req_a;
    logic [N*WB-1:0]   req_b;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [WB-1:0]     r;
    logic              err;
    logic              mm_start;
    logic [WB-1:0]     mm_a;
    logic [WB-1:0]     mm_b;
    logic [WB-1:0]     mm_r;
    logic              mm_done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int           idx;
        logic [255:0] a;
        logic [255:0] b;
        logic         err;
    } exp_t;

    exp_t exp_q[$];

    logic [N-1:0] drop_mask;
    int           stub_lat;

    always #5 clk = ~clk;

    modmul_arbiter #(.N_REQ(N), .W(WB), .WDOG_CYCLES(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_a    (req_a),
        .req_b    (req_b),
        .gnt      (gnt),
        .done     (done),
        .r        (r),
        .err      (err),
        .mm_start (mm_start),
        .mm_a     (mm_a),
        .mm_b     (mm_b),
        .mm_r     (mm_r),
        .mm_done  (mm_done)
    );

    // Reference a*b mod P by double-and-add (operands assumed already < P).
    function automatic logic [255:0] mod_mul_ref(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] acc;
        logic [256:0] pp;
        acc = '0;
        pp  = {1'b0, P};
        for (int i = 255; i >= 0; i--) begin
            acc = acc << 1;
            if (acc >= pp) acc = acc - pp;
            if (b[i]) begin
                acc = acc + {1'b0, a};
                if (acc >= pp) acc = acc - pp;
            end
        end
        return acc[255:0];
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // mod_mul stub: result after stub_lat cycles; stub_lat == 0 never answers.
    int           stub_cnt;
    logic [255:0] st_a;
    logic [255:0] st_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm_done  <= 1'b0;
            mm_r     <= '0;
            stub_cnt <= 0;
        end else begin
            mm_done <= 1'b0;
            if (mm_start) begin
                st_a     <= mm_a;
                st_b     <= mm_b;
                stub_cnt <= stub_lat;
            end else if (stub_cnt == 1) begin
                mm_done  <= 1'b1;
                mm_r     <= mod_mul_ref(st_a, st_b);
                stub_cnt <= 0;
            end else if (stub_cnt > 1) begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Per-cycle compare against the scoreboard.
    logic prev_mm_done = 1'b0;
    always @(negedge clk) begin : compare
        exp_t e;
        if (rst_n) begin
            check("gnt_onehot0", 256'($onehot0(gnt)), 256'(1));
            check("done_onehot0", 256'($onehot0(done)), 256'(1));
            if (mm_start) begin
                if (exp_q.size() == 0) begin
                    check("mm_start_unexpected", 256'(mm_start), 256'(0));
                end else begin
                    check("mm_a", mm_a, exp_q[0].a);
                    check("mm_b", mm_b, exp_q[0].b);
                end
            end
            if (prev_mm_done) check("done_latency", 256'(|done), 256'(1));
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 256'(done), 256'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("done_idx", 256'(done), 256'(1) << e.idx);
                    check("r", r, e.err ? 256'(0) : mod_mul_ref(e.a, e.b));
                    check("err", 256'(err), 256'(e.err));
                    check("gnt_at_done", 256'(gnt), 256'(done));
                end
            end else begin
                check("err_idle", 256'(err), 256'(0));
            end
            prev_mm_done = mm_done;
        end else begin
            prev_mm_done = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        req = req & ~(done & drop_mask);
    endtask

    task automatic put_op(input int i, input logic [255:0] a, input logic [255:0] b);
        req_a[i*WB +: WB] = a;
        req_b[i*WB +: WB] = b;
    endtask

    task automatic push(input int i, input logic [255:0] a, input logic [255:0] b, input logic e);
        exp_t x;
        x.idx = i; x.a = a; x.b = b; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_empty(input string name, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check(name, 256'(exp_q.size()), 256'(0));
        tick();
        tick();
    endtask

    task automatic wait_gnt(input string name, input int budget);
        int c = 0;
        while (gnt == '0 && c < budget) begin
            tick();
            c++;
        end
        check(name, 256'(gnt != '0), 256'(1));
    endtask

    // Counts done pulses; on the n-th, all requests are withdrawn.
    task automatic run_dones(input string name, input int n, input int budget);
        int seen = 0;
        int c    = 0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if (done != '0) begin
                seen++;
                if (seen == n) req = '0;
            end
            req = req & ~(done & drop_mask);
        end
        check(name, 256'(seen), 256'(n));
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 256'(gnt), 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_err"}, 256'(err), 256'(0));
        check({tag, "_mm_start"}, 256'(mm_start), 256'(0));
        check({tag, "_mm_a"}, mm_a, 256'(0));
        check({tag, "_mm_b"}, mm_b, 256'(0));
        check({tag, "_r"}, r, 256'(0));
    endtask

    initial begin : timeout
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        drop_mask = '1;
        stub_lat  = 3;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Pin the reference model with hand-computed products.
        check("model_half", mod_mul_ref(256'd2, HALF), 256'd1);
        check("model_pm1", mod_mul_ref(P - 256'd1, P - 256'd1), 256'd1);
        check("model_2p256", mod_mul_ref(256'd1 << 255, 256'd2), 256'h1_000003D1);
        check("model_small", mod_mul_ref(256'd3, 256'd5), 256'd15);

        rst_n = 1'b1;
        tick();

        // Single request with 2-edge issue latency.
        put_op(0, 256'd2, HALF);
        push(0, 256'd2, HALF, 1'b0);
        req = 4'b0001;
        tick();
        check("t1_gnt", 256'(gnt), 256'(1));
        check("t1_start_e1", 256'(mm_start), 256'(0));
        tick();
        check("t1_start_e2", 256'(mm_start), 256'(1));
        tick();
        check("t1_start_pulse", 256'(mm_start), 256'(0));
        wait_empty("t1_drain", 50);
        check("t1_r", r, 256'd1);
        check("t1_idle_gnt", 256'(gnt), 256'(0));

        // Fresh reset, then four simultaneous held requests: order 0,1,2,3,0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        put_op(0, 256'd3, 256'd5);
        put_op(1, P - 256'd1, P - 256'd1);
        put_op(2, 256'd1 << 255, 256'd2);
        put_op(3, HALF, 256'd4);
        push(0, 256'd3, 256'd5, 1'b0);
        push(1, P - 256'd1, P - 256'd1, 1'b0);
        push(2, 256'd1 << 255, 256'd2, 1'b0);
        push(3, HALF, 256'd4, 1'b0);
        push(0, 256'd3, 256'd5, 1'b0);
        drop_mask = '0;
        req = 4'b1111;
        run_dones("t2_dones", 5, 200);
        check("t2_queue", 256'(exp_q.size()), 256'(0));

        // Fairness: req[0] held, req[2] raised mid-op is served before 0 again.
        drop_mask = 4'b0100;
        put_op(0, 256'd9, 256'd11);
        put_op(2, 256'd1 << 200, 256'd1 << 100);
        push(0, 256'd9, 256'd11, 1'b0);
        push(2, 256'd1 << 200, 256'd1 << 100, 1'b0);
        push(0, 256'd9, 256'd11, 1'b0);
        req = 4'b0001;
        wait_gnt("t3_gnt", 20);
        tick();
        tick();
        req = req | 4'b0100;
        run_dones("t3_dones", 3, 200);
        check("t3_queue", 256'(exp_q.size()), 256'(0));
        drop_mask = '1;

        // Operand stability: req_a changes after grant.
        put_op(3, 256'd3, 256'd5);
        push(3, 256'd3, 256'd5, 1'b0);
        req = 4'b1000;
        wait_gnt("t4_gnt", 20);
        req_a[3*WB +: WB] = 256'd7;
        wait_empty("t4_drain", 50);
        check("t4_r", r, 256'd15);

        // Reset in the middle of WAIT against a non-answering mod_mul.
        stub_lat = 0;
        put_op(1, 256'd5, 256'd6);
        push(1, 256'd5, 256'd6, 1'b0);
        req = 4'b0010;
        wait_gnt("t5_gnt", 20);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_midwait");
        exp_q.delete();
        req = '0;
        stub_lat = 3;
        tick();
        rst_n = 1'b1;
        tick();
        put_op(1, 256'd1, 256'd1);
        push(1, 256'd1, 256'd1, 1'b0);
        req = 4'b0010;
        wait_empty("t5_drain", 50);
        check("t5_r", r, 256'd1);

`ifdef MODMUL_ARB_WDOG_EN
        // Watchdog abort after 16 WAIT cycles, then normal service resumes.
        begin
            int c;
            stub_lat = 0;
            put_op(2, 256'd4, 256'd4);
            push(2, 256'd4, 256'd4, 1'b1);
            req = 4'b0100;
            c = 0;
            while (!mm_start && c < 20) begin tick(); c++; end
            check("t6_start", 256'(mm_start), 256'(1));
            c = 0;
            do begin
                tick();
                c++;
            end while (done == '0 && c < 100);
            check("t6_wdog_cycles", 256'(c), 256'(16));
            wait_empty("t6_drain", 10);
            check("t6_r_zero", r, 256'd0);
            stub_lat = 3;
            put_op(0, 256'd6, 256'd7);
            push(0, 256'd6, 256'd7, 1'b0);
            req = 4'b0001;
            wait_empty("t6_next", 50);
            check("t6_next_r", r, 256'd42);
        end
`else
        // Without the watchdog a slow mod_mul is simply waited for.
        stub_lat = 50;
        put_op(2, 256'd4, 256'd4);
        push(2, 256'd4, 256'd4, 1'b0);
        req = 4'b0100;
        wait_empty("t6_slow_drain", 200);
        check("t6_slow_r", r, 256'd16);
        stub_lat = 3;
`endif

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
